// File: rtl/fetch_pkg.sv
// fetch_pkg: shared sequencer state encoding and fetch-path default parameters
package fetch_pkg;
   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 32;
   localparam int RESET_ADDR_DEF = 0;
   typedef enum logic [1:0] {S_START, S_RUN, S_HALT} state_t;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: execute redirect, IMEM and decode-side signals of the fetch sequencer
interface fetch_sequencer_if #(
   parameter int ADDR_W = fetch_pkg::ADDR_W_DEF,
   parameter int DATA_W = fetch_pkg::DATA_W_DEF
);
   logic              Branch;
   logic [ADDR_W-1:0] TargetAddress;
   logic              Halt;
   logic              FetchEn;
   logic [ADDR_W-1:0] FetchAddr;
   logic [DATA_W-1:0] IMemData;
   logic              InstrValid;
   logic              InstrReady;
   logic [DATA_W-1:0] Instruction;
   logic [ADDR_W-1:0] InstrAddr;
   modport master (
      input  Branch, TargetAddress, Halt, IMemData, InstrReady,
      output FetchEn, FetchAddr, InstrValid, Instruction, InstrAddr
   );
   modport slave (
      output Branch, TargetAddress, Halt, IMemData, InstrReady,
      input  FetchEn, FetchAddr, InstrValid, Instruction, InstrAddr
   );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry instruction buffer; flush beats push, head is the oldest entry
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int W = 42
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic                         flush_i,
   input  logic [W-1:0]                 din_i,
   output logic [W-1:0]                 head_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);
   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] rd_q, wr_q;
   logic [CW-1:0] count_q, count_d;
   assign count_d = count_q + CW'(push_i) - CW'(pop_i);
   assign head_o = mem_q[rd_q];
   assign count_o = count_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q <= '0;
         wr_q <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         rd_q <= '0;
         wr_q <= '0;
         count_q <= '0;
      end else begin
         if (push_i) mem_q[wr_q] <= din_i;
         if (push_i) wr_q <= wr_q + PW'(1);
         if (pop_i) rd_q <= rd_q + PW'(1);
         count_q <= count_d;
      end
   end
   // The issue rule reserves a slot for every in-flight fetch, so a full buffer is never pushed.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_i && !flush_i && count_q == CW'(DEPTH)));
   a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop_i && count_q == '0));
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, issues flow-controlled IMEM reads and buffers results for decode.
// Branch redirects flush the buffer and discard the fetch that is in flight.
module fetch_sequencer import fetch_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH = 2,
   parameter int RESET_ADDR = RESET_ADDR_DEF
) (
   input logic               clk,
   input logic               Reset,
   fetch_sequencer_if.master bus
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int W = ADDR_W + DATA_W;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, inflight_addr_q;
   logic              inflight_q, issue, pop;
   logic [CW-1:0]     count;
   logic [CW:0]       occ;
   logic [W-1:0]      head;
   assign pop = bus.InstrValid & bus.InstrReady;
   // Occupancy after this cycle's pop, counting the fetch still in flight.
   assign occ = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
   assign issue = (state_q == S_RUN) && !bus.Halt && !bus.Branch && (occ < (CW+1)'(DEPTH));
   assign bus.FetchEn = issue;
   assign bus.FetchAddr = pc_q;
   assign bus.InstrValid = (count != '0) && !bus.Branch;
   assign {bus.InstrAddr, bus.Instruction} = head;
   always_comb begin
      state_d = state_q == S_START ? S_RUN :
                state_q == S_RUN && bus.Halt ? S_HALT :
                state_q == S_HALT && !bus.Halt ? S_RUN : state_q;
      pc_d = bus.Branch ? bus.TargetAddress : issue ? pc_q + ADDR_W'(1) : pc_q;
   end
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q <= S_START;
         pc_q <= ADDR_W'(RESET_ADDR);
         inflight_q <= 1'b0;
         inflight_addr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q <= pc_d;
         inflight_q <= issue;
         if (issue) inflight_addr_q <= pc_q;
      end
   end
   fetch_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
      .clk     (clk),
      .rst     (Reset),
      .push_i  (inflight_q),
      .pop_i   (pop),
      .flush_i (bus.Branch),
      .din_i   ({inflight_addr_q, bus.IMemData}),
      .head_o  (head),
      .count_o (count)
   );
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios against a 1-cycle IMEM model returning 0xA000_0000+addr
module tb_fetch_sequencer;
   logic clk = 1'b0;
   logic Reset = 1'b0;
   int passed = 0;
   int total = 0;
   logic [9:0] exp;
   fetch_sequencer_if #(.ADDR_W(10), .DATA_W(32)) bus ();
   fetch_sequencer #(.ADDR_W(10), .DATA_W(32), .DEPTH(2), .RESET_ADDR(0)) dut (
      .clk   (clk),
      .Reset (Reset),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) if (bus.FetchEn) bus.IMemData <= 32'hA000_0000 + 32'(bus.FetchAddr);
   initial begin
      #50000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic test_reset;
      bus.Branch = 1'b0; bus.TargetAddress = '0; bus.Halt = 1'b0; bus.InstrReady = 1'b1;
      Reset = 1'b0; #1; Reset = 1'b1; #1;
      total++; if (bus.FetchEn !== 1'b0) $display("FAIL reset_fetch_en got %0b want 0", bus.FetchEn); else passed++;
      total++; if (bus.InstrValid !== 1'b0) $display("FAIL reset_valid got %0b want 0", bus.InstrValid); else passed++;
      total++; if (bus.Instruction !== 32'h0) $display("FAIL reset_instr got %h want 0", bus.Instruction); else passed++;
      total++; if (bus.InstrAddr !== 10'h0) $display("FAIL reset_iaddr got %h want 0", bus.InstrAddr); else passed++;
      total++; if (bus.FetchAddr !== 10'h0) $display("FAIL reset_faddr got %h want 0", bus.FetchAddr); else passed++;
      @(negedge clk); Reset = 1'b0;
      @(negedge clk); #1;
      total++; if (bus.FetchEn !== 1'b1 || bus.FetchAddr !== 10'h0) $display("FAIL start_fetch got en=%0b addr=%h want en=1 addr=000", bus.FetchEn, bus.FetchAddr); else passed++;
      total++; if (bus.InstrValid !== 1'b0) $display("FAIL start_valid0 got %0b want 0", bus.InstrValid); else passed++;
      @(negedge clk); #1;
      total++; if (bus.FetchEn !== 1'b1 || bus.FetchAddr !== 10'h1) $display("FAIL second_fetch got en=%0b addr=%h want en=1 addr=001", bus.FetchEn, bus.FetchAddr); else passed++;
      total++; if (bus.InstrValid !== 1'b0) $display("FAIL start_valid1 got %0b want 0", bus.InstrValid); else passed++;
      @(negedge clk); #1;
      total++; if (bus.InstrValid !== 1'b1 || bus.InstrAddr !== 10'h0 || bus.Instruction !== 32'hA000_0000) $display("FAIL first_instr got v=%0b addr=%h ins=%h want v=1 addr=000 ins=a0000000", bus.InstrValid, bus.InstrAddr, bus.Instruction); else passed++;
      exp = 10'h1;
   endtask

   task automatic test_stream;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         total++; if (bus.InstrValid !== 1'b1 || bus.InstrAddr !== exp || bus.Instruction !== 32'hA000_0000 + 32'(exp)) $display("FAIL stream[%0d] got v=%0b addr=%h ins=%h want v=1 addr=%h", i, bus.InstrValid, bus.InstrAddr, bus.Instruction, exp); else passed++;
         total++; if (bus.FetchEn !== 1'b1) $display("FAIL stream_fetch_en[%0d] got %0b want 1", i, bus.FetchEn); else passed++;
         exp++;
      end
   endtask

   task automatic test_stall;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); bus.InstrReady = 1'b0; #1;
         total++; if (bus.FetchEn !== 1'b0) $display("FAIL stall_fetch_en[%0d] got %0b want 0", i, bus.FetchEn); else passed++;
         total++; if (bus.InstrValid !== 1'b1 || bus.InstrAddr !== exp || bus.Instruction !== 32'hA000_0000 + 32'(exp)) $display("FAIL stall_hold[%0d] got v=%0b addr=%h ins=%h want v=1 addr=%h", i, bus.InstrValid, bus.InstrAddr, bus.Instruction, exp); else passed++;
      end
      @(negedge clk); bus.InstrReady = 1'b1; #1;
      total++; if (bus.FetchEn !== 1'b1) $display("FAIL resume_fetch_en got %0b want 1", bus.FetchEn); else passed++;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin @(negedge clk); #1; end
         total++; if (bus.InstrValid !== 1'b1 || bus.InstrAddr !== exp) $display("FAIL resume[%0d] got v=%0b addr=%h want v=1 addr=%h", i, bus.InstrValid, bus.InstrAddr, exp); else passed++;
         exp++;
      end
   endtask

   task automatic test_branch;
      @(negedge clk); bus.Branch = 1'b1; bus.TargetAddress = 10'h100; #1;
      total++; if (bus.InstrValid !== 1'b0 || bus.FetchEn !== 1'b0) $display("FAIL branch_cycle got v=%0b en=%0b want v=0 en=0", bus.InstrValid, bus.FetchEn); else passed++;
      @(negedge clk); bus.Branch = 1'b0; #1;
      total++; if (bus.FetchEn !== 1'b1 || bus.FetchAddr !== 10'h100) $display("FAIL branch_fetch got en=%0b addr=%h want en=1 addr=100", bus.FetchEn, bus.FetchAddr); else passed++;
      total++; if (bus.InstrValid !== 1'b0) $display("FAIL branch_killed0 got v=%0b want 0", bus.InstrValid); else passed++;
      @(negedge clk); #1;
      total++; if (bus.InstrValid !== 1'b0 || bus.FetchAddr !== 10'h101) $display("FAIL branch_killed1 got v=%0b addr=%h want v=0 addr=101", bus.InstrValid, bus.FetchAddr); else passed++;
      exp = 10'h100;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         total++; if (bus.InstrValid !== 1'b1 || bus.InstrAddr !== exp || bus.Instruction !== 32'hA000_0000 + 32'(exp)) $display("FAIL branch_seq[%0d] got v=%0b addr=%h ins=%h want v=1 addr=%h", i, bus.InstrValid, bus.InstrAddr, bus.Instruction, exp); else passed++;
         exp++;
      end
   endtask

   task automatic test_back_to_back_branch_wrap;
      @(negedge clk); bus.Branch = 1'b1; bus.TargetAddress = 10'h050; #1;
      total++; if (bus.InstrValid !== 1'b0) $display("FAIL b2b_first got v=%0b want 0", bus.InstrValid); else passed++;
      @(negedge clk); bus.TargetAddress = 10'h3FF; #1;
      total++; if (bus.InstrValid !== 1'b0 || bus.FetchEn !== 1'b0) $display("FAIL b2b_second got v=%0b en=%0b want 0 0", bus.InstrValid, bus.FetchEn); else passed++;
      @(negedge clk); bus.Branch = 1'b0; #1;
      total++; if (bus.FetchEn !== 1'b1 || bus.FetchAddr !== 10'h3FF) $display("FAIL b2b_last_wins got en=%0b addr=%h want en=1 addr=3ff", bus.FetchEn, bus.FetchAddr); else passed++;
      @(negedge clk); #1;
      total++; if (bus.FetchAddr !== 10'h000) $display("FAIL pc_wrap got %h want 000", bus.FetchAddr); else passed++;
      exp = 10'h3FF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         total++; if (bus.InstrValid !== 1'b1 || bus.InstrAddr !== exp || bus.Instruction !== 32'hA000_0000 + 32'(exp)) $display("FAIL wrap_seq[%0d] got v=%0b addr=%h ins=%h want v=1 addr=%h", i, bus.InstrValid, bus.InstrAddr, bus.Instruction, exp); else passed++;
         exp++;
      end
   endtask

   task automatic test_halt;
      @(negedge clk); bus.Halt = 1'b1; #1;
      total++; if (bus.FetchEn !== 1'b0 || bus.InstrValid !== 1'b1 || bus.InstrAddr !== exp) $display("FAIL halt_h0 got en=%0b v=%0b addr=%h want en=0 v=1 addr=%h", bus.FetchEn, bus.InstrValid, bus.InstrAddr, exp); else passed++;
      exp++;
      @(negedge clk); #1;
      total++; if (bus.FetchEn !== 1'b0 || bus.InstrValid !== 1'b1 || bus.InstrAddr !== exp) $display("FAIL halt_inflight got en=%0b v=%0b addr=%h want en=0 v=1 addr=%h", bus.FetchEn, bus.InstrValid, bus.InstrAddr, exp); else passed++;
      @(negedge clk); bus.Branch = 1'b1; bus.TargetAddress = 10'h020; #1;
      total++; if (bus.FetchEn !== 1'b0 || bus.InstrValid !== 1'b0) $display("FAIL halt_branch got en=%0b v=%0b want 0 0", bus.FetchEn, bus.InstrValid); else passed++;
      @(negedge clk); bus.Branch = 1'b0; #1;
      total++; if (bus.FetchEn !== 1'b0 || bus.InstrValid !== 1'b0) $display("FAIL halt_h3 got en=%0b v=%0b want 0 0", bus.FetchEn, bus.InstrValid); else passed++;
      @(negedge clk); bus.Halt = 1'b0; #1;
      total++; if (bus.FetchEn !== 1'b0) $display("FAIL unhalt_cycle got en=%0b want 0", bus.FetchEn); else passed++;
      @(negedge clk); #1;
      total++; if (bus.FetchEn !== 1'b1 || bus.FetchAddr !== 10'h020) $display("FAIL unhalt_fetch got en=%0b addr=%h want en=1 addr=020", bus.FetchEn, bus.FetchAddr); else passed++;
      @(negedge clk); #1;
      total++; if (bus.InstrValid !== 1'b0) $display("FAIL unhalt_latency got v=%0b want 0", bus.InstrValid); else passed++;
      @(negedge clk); #1;
      total++; if (bus.InstrValid !== 1'b1 || bus.InstrAddr !== 10'h020 || bus.Instruction !== 32'hA000_0020) $display("FAIL unhalt_first got v=%0b addr=%h ins=%h want v=1 addr=020 ins=a0000020", bus.InstrValid, bus.InstrAddr, bus.Instruction); else passed++;
   endtask

   task automatic test_async_reset;
      @(negedge clk); #2;
      total++; if (bus.InstrValid !== 1'b1 || bus.FetchEn !== 1'b1) $display("FAIL pre_reset got v=%0b en=%0b want 1 1", bus.InstrValid, bus.FetchEn); else passed++;
      Reset = 1'b1; #1;
      total++; if (bus.InstrValid !== 1'b0 || bus.FetchEn !== 1'b0 || bus.FetchAddr !== 10'h0) $display("FAIL async_reset got v=%0b en=%0b addr=%h want 0 0 000", bus.InstrValid, bus.FetchEn, bus.FetchAddr); else passed++;
      @(posedge clk); @(negedge clk); Reset = 1'b0;
      @(negedge clk); #1;
      total++; if (bus.FetchEn !== 1'b1 || bus.FetchAddr !== 10'h0 || bus.InstrValid !== 1'b0) $display("FAIL restart_fetch got en=%0b addr=%h v=%0b want 1 000 0", bus.FetchEn, bus.FetchAddr, bus.InstrValid); else passed++;
      @(negedge clk); #1;
      total++; if (bus.FetchAddr !== 10'h1 || bus.InstrValid !== 1'b0) $display("FAIL restart_second got addr=%h v=%0b want 001 0", bus.FetchAddr, bus.InstrValid); else passed++;
      @(negedge clk); #1;
      total++; if (bus.InstrValid !== 1'b1 || bus.InstrAddr !== 10'h0 || bus.Instruction !== 32'hA000_0000) $display("FAIL restart_first got v=%0b addr=%h ins=%h want 1 000 a0000000", bus.InstrValid, bus.InstrAddr, bus.Instruction); else passed++;
      @(negedge clk); #1;
      total++; if (bus.InstrValid !== 1'b1 || bus.InstrAddr !== 10'h1) $display("FAIL restart_next got v=%0b addr=%h want 1 001", bus.InstrValid, bus.InstrAddr); else passed++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_branch();
      test_back_to_back_branch_wrap();
      test_halt();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
